// File: rtl/mul16_seq_if.sv
// Start/done handshake and operand/result bus of the sequential 16-bit multiplier.
interface mul16_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16-bit shift-and-add multiplier: one time-shared add16, IDLE/RUN/DONE FSM.
// Returns the low 16 bits of a*b (same bits for signed and unsigned operands).
module add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] sum
);
    assign sum = x + y;
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one shift-and-add step per clock
// DONE  | product valid, done pulses for one cycle, then back to IDLE
module mul16_seq #(
    parameter bit EARLY_DONE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    mul16_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;
    logic [15:0] product;
    logic [15:0] sum;
    logic [15:0] acc_nxt;
    logic [15:0] mplier_nxt;
    logic        last_step;

    add16 u_add16 (.x(acc), .y(mcand), .sum(sum));

    assign acc_nxt    = mplier[0] ? sum : acc;
    assign mplier_nxt = {1'b0, mplier[15:1]};
    // Early exit once no multiplier bits remain; the step count still caps at 16.
    assign last_step  = (cnt == 4'd15) || (EARLY_DONE && (mplier_nxt == 16'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.product = product;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 16'd0;
            mcand   <= 16'd0;
            mplier  <= 16'd0;
            cnt     <= 4'd0;
            product <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= 16'd0;
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        cnt    <= 4'd0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[14:0], 1'b0};
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 4'd1;
                    if (last_step) begin
                        product <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: fixed-length and early-done instances against a cycle-level
// behavioural model, plus directed literal checks and a long random back-to-back run.
module tb_mul16_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul16_seq_if i0 ();
    mul16_seq_if i1 ();

    mul16_seq #(.EARLY_DONE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    mul16_seq #(.EARLY_DONE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] prod_w [2];
    assign busy_w[0] = i0.busy;
    assign busy_w[1] = i1.busy;
    assign done_w[0] = i0.done;
    assign done_w[1] = i1.done;
    assign prod_w[0] = i0.product;
    assign prod_w[1] = i1.product;

    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    assign i0.start = start;
    assign i1.start = start;
    assign i0.a = op_a;
    assign i1.a = op_a;
    assign i0.b = op_b;
    assign i1.b = op_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Number of RUN steps an operation takes.
    function automatic int op_steps(input int early, input logic [15:0] mb);
        if (early == 0) return 16;
        for (int i = 15; i >= 0; i--) if (mb[i]) return i + 1;
        return 1;
    endfunction

    // Model: remaining busy cycles per instance (RUN steps + one DONE cycle).
    int          m_rem  [2];
    logic [15:0] m_pend [2];
    logic [15:0] m_prod [2];
    int          ndone  [2];

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] full;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_rem[d]  = 0;
                m_pend[d] = 16'd0;
                m_prod[d] = 16'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_rem[d] == 0) begin
                    if (start) begin
                        full      = {16'd0, op_a} * {16'd0, op_b};
                        m_pend[d] = full[15:0];
                        m_rem[d]  = op_steps(d, op_b) + 1;
                    end
                end else begin
                    m_rem[d] = m_rem[d] - 1;
                    if (m_rem[d] == 1) m_prod[d] = m_pend[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cmp_busy%0d", d), 32'(busy_w[d]), 32'(m_rem[d] != 0));
            chk($sformatf("cmp_done%0d", d), 32'(done_w[d]), 32'(m_rem[d] == 1));
            chk($sformatf("cmp_prod%0d", d), 32'(prod_w[d]), 32'(m_prod[d]));
            if (done_w[d] === 1'b1) ndone[d]++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One operation on both instances; checks done timing, product, busy and pulse count.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic [15:0] exp, input int st0, input int st1,
                          input bit inject);
        int n;
        int seen [2];
        int cnt  [2];
        int st   [2];
        st[0] = st0;
        st[1] = st1;
        seen[0] = 0; seen[1] = 0; cnt[0] = 0; cnt[1] = 0;
        start = 1'b1; op_a = ta; op_b = tb;
        step();
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        n = 1;
        chk("busy_after_e0_0", 32'(busy_w[0]), 32'd1);
        chk("busy_after_e0_1", 32'(busy_w[1]), 32'd1);
        while ((seen[0] == 0 || seen[1] == 0) && n < 40) begin
            for (int d = 0; d < 2; d++) begin
                if (done_w[d]) begin
                    cnt[d]++;
                    if (seen[d] == 0) begin
                        seen[d] = n;
                        chk($sformatf("prod_lit%0d", d), 32'(prod_w[d]), 32'(exp));
                    end
                end
            end
            if (inject && n == 5) begin
                start = 1'b1; op_a = 16'd9; op_b = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (seen[0] == 0 || seen[1] == 0) begin
                step();
                n++;
            end
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            for (int d = 0; d < 2; d++) if (done_w[d]) cnt[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("done_cycle%0d", d), 32'(seen[d]), 32'(st[d] + 1));
            chk($sformatf("done_pulses%0d", d), 32'(cnt[d]), 32'd1);
            chk($sformatf("prod_hold%0d", d), 32'(prod_w[d]), 32'(exp));
        end
    endtask

    initial begin
        int base0;
        int cyc;
        start = 1'b0; op_a = 16'd0; op_b = 16'd0;
        ndone[0] = 0; ndone[1] = 0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 32'(busy_w[d]), 32'd0);
            chk("rst_done", 32'(done_w[d]), 32'd0);
            chk("rst_prod", 32'(prod_w[d]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) step();

        run_op(16'd3,     16'd5,     16'd15,     16, 3,  1'b0);
        run_op(16'h7FFF,  16'd2,     16'hFFFE,   16, 2,  1'b0);
        run_op(16'hFFFF,  16'hFFFF,  16'h0001,   16, 16, 1'b0);
        run_op(16'h8000,  16'hFFFF,  16'h8000,   16, 16, 1'b0);
        run_op(16'd1000,  16'hC003,  16'd3000,   16, 16, 1'b1);
        run_op(16'd1234,  16'd1,     16'd1234,   16, 1,  1'b0);
        run_op(16'd4321,  16'd0,     16'd0,      16, 1,  1'b0);
        run_op(16'd3,     16'h8000,  16'h8000,   16, 16, 1'b0);

        // Reset in the middle of an operation discards it.
        start = 1'b1; op_a = 16'd100; op_b = 16'd200;
        step();
        start = 1'b0;
        repeat (6) step();
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_busy", 32'(busy_w[d]), 32'd0);
            chk("midrst_done", 32'(done_w[d]), 32'd0);
            chk("midrst_prod", 32'(prod_w[d]), 32'd0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        run_op(16'd100, 16'd200, 16'd20000, 16, 8, 1'b0);

        // Back-to-back random operations with start held high.
        base0 = ndone[0];
        cyc = 0;
        start = 1'b1;
        while (ndone[0] - base0 < 1000 && cyc < 20000) begin
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            step();
            cyc++;
        end
        start = 1'b0;
        repeat (20) step();
        chk("rand_done_count", 32'(ndone[0] - base0), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
